// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 bus multiplexer tree; one 2:1 level per register stage, sel echoed on the output.
// Latency LEVELS = log2(N_IN) cycles from input transfer to out_valid; one transfer per cycle sustained.
// Backpressure ripples combinationally from out_ready to in_ready; empty stages always load (bubbles collapse).
module mux_tree_pipe #(
    parameter  int WIDTH  = 8,
    parameter  int N_IN   = 8,
    localparam int LEVELS = $clog2(N_IN),
    localparam int SEL_W  = LEVELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Every level of the tree, including the combinational input level 0, is
    // viewed as one flat lane array. Level l starts at lane lvl_off(l) and has
    // N_IN>>l lanes; levels 1..LEVELS are the registered stages.
    localparam int TREE_LANES = 2 * N_IN - 1;

    if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_fan_in
        $error("mux_tree_pipe: N_IN must be a power of two and at least 2");
    end

    function automatic int lvl_off(input int l);
        return 2 * N_IN - 2 * (N_IN >> l);
    endfunction

    // Registered lanes of levels 1..LEVELS, packed back to back (N_IN-1 lanes).
    logic [(N_IN-1)*WIDTH-1:0]  stage_q;
    logic [(N_IN-1)*WIDTH-1:0]  stage_d;
    logic [SEL_W-1:0]           sel_q [1:LEVELS];
    logic [LEVELS:1]            vld_q;
    logic [LEVELS:1]            adv;
    logic                       adv_run;

    // Level 0 (the input) followed by the registered levels.
    logic [TREE_LANES*WIDTH-1:0] tree;
    logic [SEL_W-1:0]            sel_chain [0:LEVELS];
    logic [LEVELS:0]             vld_chain;

    assign tree      = {stage_q, in_data};
    assign vld_chain = {vld_q, in_valid};

    // Gather each stage's copy of sel, with the raw input as level 0.
    always_comb begin
        sel_chain[0] = in_sel;
        for (int l = 1; l <= LEVELS; l++) begin
            sel_chain[l] = sel_q[l];
        end
    end

    // Advance enables: a stage may load if the stage after it moves or it is empty.
    always_comb begin
        adv     = '0;
        adv_run = out_ready || !vld_q[LEVELS];
        adv[LEVELS] = adv_run;
        for (int l = LEVELS - 1; l >= 1; l--) begin
            adv_run = adv_run || !vld_q[l];
            adv[l]  = adv_run;
        end
    end

    // 2:1 selection per level: lane j of level l picks lane 2j or 2j+1 of level l-1
    // using bit l-1 of the sel copy that travels with the previous level.
    always_comb begin
        stage_d = '0;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < N_IN / 2; j++) begin
                if (j < (N_IN >> l)) begin
                    stage_d[(lvl_off(l) - N_IN + j)*WIDTH +: WIDTH] =
                        tree[(lvl_off(l-1) + 2*j + int'(sel_chain[l-1][l-1]))*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Stage registers: each level loads from the previous one only when it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            vld_q   <= '0;
            for (int l = 1; l <= LEVELS; l++) begin
                sel_q[l] <= '0;
            end
        end else begin
            for (int l = 1; l <= LEVELS; l++) begin
                if (adv[l]) begin
                    vld_q[l] <= vld_chain[l-1];
                    sel_q[l] <= sel_chain[l-1];
                    for (int j = 0; j < N_IN / 2; j++) begin
                        if (j < (N_IN >> l)) begin
                            stage_q[(lvl_off(l) - N_IN + j)*WIDTH +: WIDTH] <=
                                stage_d[(lvl_off(l) - N_IN + j)*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

    // The last lane of the tree is the single output lane of level LEVELS.
    assign out_data  = tree[(TREE_LANES-1)*WIDTH +: WIDTH];
    assign out_sel   = sel_chain[LEVELS];
    assign out_valid = vld_chain[LEVELS];
    assign in_ready  = adv[1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: 8:1 x 8-bit instance plus a 2:1 x 16-bit instance.
// Scoreboard entries are pushed at input transfer and popped at output transfer.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mux_tree_pipe;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int LV = 3;

    logic clk = 1'b0;
    logic rst;

    logic [N*W-1:0]  in_data;
    logic [LV-1:0]   in_sel;
    logic            in_valid, in_ready;
    logic [W-1:0]    out_data;
    logic [LV-1:0]   out_sel;
    logic            out_valid, out_ready;

    logic [31:0]     in_data2;
    logic            in_sel2, in_valid2, in_ready2;
    logic [15:0]     out_data2;
    logic            out_sel2, out_valid2, out_ready2;

    mux_tree_pipe #(.WIDTH(W), .N_IN(N)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_tree_pipe #(.WIDTH(16), .N_IN(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data2), .in_sel(in_sel2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [10:0] sb [$];
    logic [16:0] sb2 [$];
    logic [W-1:0] lane_val [N];

    logic           s_rdy, s_vld, s_acc, s_del;
    logic [W-1:0]   s_dat;
    logic [LV-1:0]  s_sel;
    logic           s2_vld, s2_acc, s2_del, s2_sel;
    logic [15:0]    s2_dat;

    task automatic set_lanes();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = lane_val[i];
    endtask

    // One clock: sample at the falling edge, record accepted items, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_rdy  = in_ready;  s_vld = out_valid; s_dat = out_data; s_sel = out_sel;
        s_acc  = in_valid && in_ready && !rst;
        s_del  = out_valid && out_ready && !rst;
        s2_vld = out_valid2; s2_dat = out_data2; s2_sel = out_sel2;
        s2_acc = in_valid2 && in_ready2 && !rst;
        s2_del = out_valid2 && out_ready2 && !rst;
        if (s_acc)  sb.push_back({in_sel, lane_val[in_sel]});
        if (s2_acc) sb2.push_back({in_sel2, in_sel2 ? in_data2[31:16] : in_data2[15:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        tests++; if (s_vld !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", s_vld); end
        tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL rst_in_ready_during: got %b want 1", s_rdy); end
        rst = 1'b0;
        cycle();
        tests++; if (s_dat !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h want 00", s_dat); end
        tests++; if (s_sel !== 3'd0) begin fails++; $display("FAIL rst_out_sel: got %0d want 0", s_sel); end
        tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL rst_in_ready_after: got %b want 1", s_rdy); end
        tests++; if (s2_vld !== 1'b0 || s2_dat !== 16'h0) begin fails++; $display("FAIL rst_n2_out: got vld=%b dat=%h want 0/0000", s2_vld, s2_dat); end
    endtask

    task automatic test_single();
        logic [10:0] exp;
        for (int i = 0; i < N; i++) lane_val[i] = 8'h10 + 8'(i);
        set_lanes();
        out_ready = 1'b1;
        in_sel = 3'd5; in_valid = 1'b1;
        cycle();
        tests++; if (s_acc !== 1'b1) begin fails++; $display("FAIL single_accept: got %b want 1", s_acc); end
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            tests++; if (s_vld !== (k == 3)) begin fails++; $display("FAIL single_valid_c%0d: got %b want %b", k, s_vld, (k == 3)); end
            if (k == 3) begin
                tests++; if (s_dat !== 8'h15 || s_sel !== 3'd5) begin fails++; $display("FAIL single_data: got %h/%0d want 15/5", s_dat, s_sel); end
            end
            if (s_del) begin
                tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL single_extra_item: got %h with empty scoreboard", s_dat); end
                else begin exp = sb.pop_front(); if ({s_sel, s_dat} !== exp) begin fails++; $display("FAIL single_sb: got %h want %h", {s_sel, s_dat}, exp); end end
            end
        end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL single_left: got %0d items left want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 8);
            in_sel   = 3'(k);
            cycle();
            if (k < 8) begin
                tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", k, s_rdy); end
            end
            tests++; if (s_vld !== (k >= 3 && k <= 10)) begin fails++; $display("FAIL b2b_valid_c%0d: got %b want %b", k, s_vld, (k >= 3 && k <= 10)); end
            if (s_del) begin
                tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL b2b_extra_item: got %h with empty scoreboard", s_dat); end
                else begin exp = sb.pop_front(); if ({s_sel, s_dat} !== exp) begin fails++; $display("FAIL b2b_sb_c%0d: got %h want %h", k, {s_sel, s_dat}, exp); end end
            end
        end
        in_valid = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_left: got %0d items left want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [2:0] sels [5] = '{3'd2, 3'd7, 3'd1, 3'd4, 3'd6};
        logic [10:0] exp;
        int idx = 0;
        int ndel = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_sel   = sels[idx];
            cycle();
            if (s_acc) idx++;
            tests++; if (s_rdy !== (k < 3)) begin fails++; $display("FAIL bp_in_ready_c%0d: got %b want %b", k, s_rdy, (k < 3)); end
            if (k >= 3) begin
                tests++; if (s_vld !== 1'b1 || s_dat !== 8'h12 || s_sel !== 3'd2) begin fails++; $display("FAIL bp_frozen_c%0d: got %b/%h/%0d want 1/12/2", k, s_vld, s_dat, s_sel); end
            end
        end
        tests++; if (idx != 3) begin fails++; $display("FAIL bp_accepted: got %0d want 3", idx); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 0) begin
                tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL bp_ready_on_release: got %b want 1", s_rdy); end
            end
            if (s_del) begin
                ndel++;
                tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL bp_extra_item: got %h with empty scoreboard", s_dat); end
                else begin exp = sb.pop_front(); if ({s_sel, s_dat} !== exp) begin fails++; $display("FAIL bp_sb: got %h want %h", {s_sel, s_dat}, exp); end end
            end
        end
        tests++; if (ndel != 3 || sb.size() != 0) begin fails++; $display("FAIL bp_drain: got %0d delivered %0d left want 3/0", ndel, sb.size()); end
    endtask

    task automatic test_full_toggle();
        logic [10:0] exp;
        logic [10:0] prev_word = '0;
        logic        prev_stall = 1'b0;
        int nacc = 0, ndel = 0, occ, ndrain = 0;
        in_valid = 1'b1;
        in_sel   = 3'($urandom_range(0, 7));
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) lane_val[i] = 8'($urandom);
            set_lanes();
            out_ready = (k % 2 == 0);
            cycle();
            if (prev_stall) begin
                tests++; if ({s_sel, s_dat} !== prev_word) begin fails++; $display("FAIL tog_hold_c%0d: got %h want %h", k, {s_sel, s_dat}, prev_word); end
            end
            prev_stall = s_vld && !s_del;
            prev_word  = {s_sel, s_dat};
            if (s_acc) begin nacc++; in_sel = 3'($urandom_range(0, 7)); end
            if (s_del) begin
                ndel++;
                tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL tog_extra_item: got %h with empty scoreboard", s_dat); end
                else begin exp = sb.pop_front(); if ({s_sel, s_dat} !== exp) begin fails++; $display("FAIL tog_sb_c%0d: got %h want %h", k, {s_sel, s_dat}, exp); end end
            end
        end
        occ = sb.size();
        tests++; if (occ != 3) begin fails++; $display("FAIL tog_occupancy: got %0d want 3", occ); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_del) begin
                ndrain++;
                tests++;
                if (sb.size() == 0) begin fails++; $display("FAIL tog_drain_extra: got %h with empty scoreboard", s_dat); end
                else begin exp = sb.pop_front(); if ({s_sel, s_dat} !== exp) begin fails++; $display("FAIL tog_drain_sb: got %h want %h", {s_sel, s_dat}, exp); end end
            end
        end
        tests++; if (nacc != ndel + ndrain || ndrain != occ) begin fails++; $display("FAIL tog_conservation: got acc=%0d del=%0d drain=%0d want acc=del+drain, drain=%0d", nacc, ndel, ndrain, occ); end
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_sel = 3'(k + 4);
            cycle();
        end
        tests++; if (sb.size() != 3) begin fails++; $display("FAIL rf_fill: got %0d accepted want 3", sb.size()); end
        rst = 1'b1;
        in_sel = 3'd3;
        cycle();
        cycle();
        tests++; if (s_rdy !== 1'b1 || s_vld !== 1'b0) begin fails++; $display("FAIL rf_during: got rdy=%b vld=%b want 1/0", s_rdy, s_vld); end
        sb.delete();
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        tests++; if (s_vld !== 1'b0 || s_dat !== 8'h00 || s_sel !== 3'd0 || s_rdy !== 1'b1) begin fails++; $display("FAIL rf_after: got vld=%b dat=%h sel=%0d rdy=%b want 0/00/0/1", s_vld, s_dat, s_sel, s_rdy); end
        for (int k = 0; k < 6; k++) begin
            cycle();
            tests++; if (s_vld !== 1'b0) begin fails++; $display("FAIL rf_stale_c%0d: got valid %b data %h want 0", k, s_vld, s_dat); end
        end
    endtask

    task automatic test_n2();
        logic [16:0] exp;
        int ndel = 0;
        in_data2   = {16'h5555, 16'hAAAA};
        out_ready2 = 1'b1;
        in_sel2 = 1'b1; in_valid2 = 1'b1;
        cycle();
        in_sel2 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            in_valid2 = 1'b0;
            if (k == 1) begin
                tests++; if (s2_vld !== 1'b1 || s2_dat !== 16'h5555 || s2_sel !== 1'b1) begin fails++; $display("FAIL n2_first: got %b/%h/%b want 1/5555/1", s2_vld, s2_dat, s2_sel); end
            end
            if (k == 2) begin
                tests++; if (s2_vld !== 1'b1 || s2_dat !== 16'hAAAA || s2_sel !== 1'b0) begin fails++; $display("FAIL n2_second: got %b/%h/%b want 1/aaaa/0", s2_vld, s2_dat, s2_sel); end
            end
            if (k == 3) begin
                tests++; if (s2_vld !== 1'b0) begin fails++; $display("FAIL n2_idle: got %b want 0", s2_vld); end
            end
            if (s2_del) begin
                ndel++;
                tests++;
                if (sb2.size() == 0) begin fails++; $display("FAIL n2_extra_item: got %h with empty scoreboard", s2_dat); end
                else begin exp = sb2.pop_front(); if ({s2_sel, s2_dat} !== exp) begin fails++; $display("FAIL n2_sb: got %h want %h", {s2_sel, s2_dat}, exp); end end
            end
        end
        tests++; if (ndel != 2) begin fails++; $display("FAIL n2_count: got %0d want 2", ndel); end
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_data2 = '0; in_sel2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        for (int i = 0; i < N; i++) lane_val[i] = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_toggle();
        test_reset_flight();
        test_n2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
